alu_mc: RTL and testbench

Multi-cycle execute-stage ALU that consumes the 4-bit operation code produced by `alu_control` and the two operands from the register-read stage, and returns a registered result to the pipeline. Single-cycle operations (AND/OR/ADD/SUB/SLL/SRL/SLT) complete in one cycle. MUL uses an iterative shift-add multiplier; the block deasserts `in_ready` while it runs so the core can stall the front end.

---
 rtl/alu_pkg.sv | 19 +
 rtl/mul_iter.sv | 64 ++++++
 rtl/alu_mc.sv | 138 +++++++++++++
 tb/tb_alu_mc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes
// Purpose: single source of the 4-bit op codes used by alu_control and alu_mc.
// Ports: none (package).
package alu_pkg;

  localparam logic [3:0] AND_OP = 4'd0;
  localparam logic [3:0] OR_OP  = 4'd1;
  localparam logic [3:0] ADD_OP = 4'd2;
  localparam logic [3:0] SLL_OP = 4'd3;
  localparam logic [3:0] SRL_OP = 4'd4;
  localparam logic [3:0] SUB_OP = 4'd6;
  localparam logic [3:0] SLT_OP = 4'd7;
  localparam logic [3:0] MUL_OP = 4'd8;

  function automatic logic is_mul(input logic [3:0] op);
    return op == MUL_OP;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
// Purpose: computes the low DATA_W bits of op_a * op_b in DATA_W cycles.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          load operands and begin (ignored while busy)
//   op_a, op_b     multiplicand, multiplier
//   busy           iteration in progress
//   done           high during the final iteration (count == DATA_W-1)
//   product        accumulator including this cycle's partial product;
//                  equals the final result while done is high
module mul_iter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_acc;
  logic [CW-1:0]     r_count;
  logic              r_busy;
  logic [DATA_W-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign busy       = r_busy;
  assign done       = r_busy && (r_count == LAST);
  assign product    = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (start && !r_busy) begin
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_acc    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      // Wraps back to 0 after the last iteration, ready for the next start.
      r_count  <= r_count + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle execute-stage ALU with registered result
// Purpose: single-cycle AND/OR/ADD/SUB/SLL/SRL/SLT, iterative MUL; stalls via in_ready.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   alu_control    4-bit op code (alu_pkg)
//   alu_in_0/1     operands A/B; B[log2(DATA_W)-1:0] is the shift amount
//   in_valid       request present; accepted when in_ready is high
//   in_ready       high only in IDLE
//   alu_out        registered result, held until the next result
//   zero_flag      registered (alu_out == 0)
//   res_valid      one-cycle pulse on each new alu_out
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_W = 64  // power of two, >= 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag,
  output logic              res_valid
);

  localparam int SHW = $clog2(DATA_W);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_accept;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;
  logic [DATA_W-1:0] w_alu_res;
  logic [SHW-1:0]    w_shamt;
  logic              w_slt;

  logic [DATA_W-1:0] r_alu_out;
  logic              r_zero;
  logic              r_res_valid;

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .op_a    (alu_in_0),
    .op_b    (alu_in_1),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // in_ready depends only on r_state, so in_valid never reaches an output combinationally.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    w_accept     = 1'b0;
    w_mul_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          if (is_mul(alu_control)) begin
            w_mul_start  = 1'b1;
            w_next_state = S_MUL;
          end
        end
      end
      S_MUL: begin
        // Leaving on !busy as well keeps the FSM from sticking if the
        // multiplier ever stops without raising done.
        if (w_mul_done || !w_mul_busy) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_shamt = alu_in_1[SHW-1:0];
  assign w_slt   = $signed(alu_in_0) < $signed(alu_in_1);

  always_comb begin
    w_alu_res = '0;
    case (alu_control)
      AND_OP:  w_alu_res = alu_in_0 & alu_in_1;
      OR_OP:   w_alu_res = alu_in_0 | alu_in_1;
      ADD_OP:  w_alu_res = alu_in_0 + alu_in_1;
      SUB_OP:  w_alu_res = alu_in_0 - alu_in_1;
      SLL_OP:  w_alu_res = alu_in_0 << w_shamt;
      SRL_OP:  w_alu_res = alu_in_0 >> w_shamt;
      SLT_OP:  w_alu_res = {{(DATA_W-1){1'b0}}, w_slt};
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out   <= '0;
      r_zero      <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_mul_done) begin
        r_alu_out   <= w_mul_product;
        r_zero      <= (w_mul_product == '0);
        r_res_valid <= 1'b1;
      end else if (w_accept && !w_mul_start) begin
        r_alu_out   <= w_alu_res;
        r_zero      <= (w_alu_res == '0);
        r_res_valid <= 1'b1;
      end
    end
  end

  assign alu_out   = r_alu_out;
  assign zero_flag = r_zero;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_control;
  logic [63:0] alu_in_0;
  logic [63:0] alu_in_1;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_out;
  logic        zero_flag;
  logic        res_valid;

  int n_cmp = 0;
  int n_err = 0;

  alu_mc #(.DATA_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_control (alu_control),
    .alu_in_0    (alu_in_0),
    .alu_in_1    (alu_in_1),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_out     (alu_out),
    .zero_flag   (zero_flag),
    .res_valid   (res_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    alu_control = op;
    alu_in_0    = a;
    alu_in_1    = b;
    in_valid    = 1'b1;
  endtask

  // Single-cycle op issued from IDLE; result checked in cycle 1.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    drive(op, a, b);
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
    chk({tag, "_out"}, alu_out, exp);
    chk({tag, "_zero"}, {63'd0, zero_flag}, {63'd0, exp == 64'd0});
    tick();
  endtask

  logic bad_ready;
  logic bad_valid;

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    alu_control = 4'd0;
    alu_in_0    = '0;
    alu_in_1    = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out", alu_out, 64'd0);
    chk("rst_zero", {63'd0, zero_flag}, 64'd1);
    chk("rst_valid", {63'd0, res_valid}, 64'd0);

    // ADD 5+7 then SUB 9-9 back to back
    drive(ADD_OP, 64'd5, 64'd7);
    tick();
    chk("add_valid", {63'd0, res_valid}, 64'd1);
    chk("add_out", alu_out, 64'd12);
    chk("add_zero", {63'd0, zero_flag}, 64'd0);
    drive(SUB_OP, 64'd9, 64'd9);
    tick();
    in_valid = 1'b0;
    chk("sub_valid", {63'd0, res_valid}, 64'd1);
    chk("sub_out", alu_out, 64'd0);
    chk("sub_zero", {63'd0, zero_flag}, 64'd1);
    tick();
    chk("idle_valid", {63'd0, res_valid}, 64'd0);
    chk("hold_out", alu_out, 64'd0);

    // MUL all-ones * 3: busy cycles 1..64, result cycle 65
    drive(MUL_OP, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    tick();
    in_valid  = 1'b0;
    bad_ready = 1'b0;
    bad_valid = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      if (res_valid !== 1'b0) bad_valid = 1'b1;
      tick();
    end
    chk("mul_busy_ready", {63'd0, bad_ready}, 64'd0);
    chk("mul_busy_valid", {63'd0, bad_valid}, 64'd0);
    chk("mul_valid", {63'd0, res_valid}, 64'd1);
    chk("mul_ready", {63'd0, in_ready}, 64'd1);
    chk("mul_out", alu_out, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("mul_zero", {63'd0, zero_flag}, 64'd0);
    tick();

    run_op("slt_neg", SLT_OP, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    run_op("slt_pos", SLT_OP, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run_op("sll", SLL_OP, 64'd1, 64'd65, 64'd2);
    run_op("srl", SRL_OP, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
    run_op("and", AND_OP, 64'hF0F0, 64'hFF00, 64'hF000);
    run_op("or", OR_OP, 64'hF0F0, 64'h0F0F, 64'hFFFF);
    run_op("add_ovf", ADD_OP, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
    run_op("undef9", 4'd9, 64'd5, 64'd7, 64'd0);
    run_op("undef5", 4'd5, 64'd5, 64'd7, 64'd0);

    // MUL 6*7, then ADD 1+1 held through the busy window
    drive(MUL_OP, 64'd6, 64'd7);
    tick();
    drive(ADD_OP, 64'd1, 64'd1);
    bad_ready = 1'b0;
    bad_valid = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      if (res_valid !== 1'b0) bad_valid = 1'b1;
      tick();
    end
    chk("hold_busy_ready", {63'd0, bad_ready}, 64'd0);
    chk("hold_busy_valid", {63'd0, bad_valid}, 64'd0);
    chk("mul42_valid", {63'd0, res_valid}, 64'd1);
    chk("mul42_out", alu_out, 64'd42);
    chk("mul42_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("add2_valid", {63'd0, res_valid}, 64'd1);
    chk("add2_out", alu_out, 64'd2);
    tick();

    // MUL aborted by reset in cycle 10
    drive(MUL_OP, 64'd6, 64'd7);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", {63'd0, res_valid}, 64'd0);
    chk("abort_out", alu_out, 64'd0);
    chk("abort_zero", {63'd0, zero_flag}, 64'd1);
    chk("abort_ready", {63'd0, in_ready}, 64'd1);
    drive(ADD_OP, 64'd3, 64'd4);
    tick();
    in_valid = 1'b0;
    chk("post_add_valid", {63'd0, res_valid}, 64'd1);
    chk("post_add_out", alu_out, 64'd7);
    tick();
    bad_valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (res_valid !== 1'b0) bad_valid = 1'b1;
      tick();
    end
    chk("no_stray_valid", {63'd0, bad_valid}, 64'd0);
    chk("final_out", alu_out, 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
